// File: rtl/uart_tx_arbiter_if.sv
// Requester / transmitter bundle for uart_tx_arbiter.
// slave: arbiter side; master: requesters + transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           grant;
  logic                         tx_start;
  logic [DATA_BITS-1:0]         tx_din;
  logic                         tx_done_tick;
  logic                         busy;
  logic                         timeout_err;

  modport slave (
    input  req_valid, req_data, req_last,
    input  tx_done_tick,
    output req_ready, grant,
    output tx_start, tx_din,
    output busy, timeout_err
  );

  modport master (
    output req_valid, req_data, req_last,
    output tx_done_tick,
    input  req_ready, grant,
    input  tx_start, tx_din,
    input  busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin burst arbiter sharing one UART transmitter.
// Ports: clk, reset_n (async low), bus (uart_tx_arbiter_if.slave).
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_BITS  = 8,
  parameter int MAX_BURST  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic clk,
  input  logic reset_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int GN = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int GW = $clog2(GN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_SEND, S_WAIT, S_GAP
  } state_t;

  state_t               r_state, w_next;
  logic [IW-1:0]        r_owner, r_last_grant, w_pick;
  logic [NUM_REQ-1:0]   r_grant, w_pick_oh;
  logic [7:0]           r_beat;
  logic                 r_last_flag;
  logic                 r_timeout_err;
  logic [TW-1:0]        r_wd;
  logic [GW-1:0]        r_gap;
  logic [DATA_BITS-1:0] w_words [NUM_REQ];
  logic w_any, w_own_valid, w_send;
  logic w_wd_exp, w_burst_end, w_to_gap;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign w_words[g] =
      bus.req_data[g*DATA_BITS +: DATA_BITS];
  end

  // Scan downward so the last hit is the
  // first set bit after last_grant.
  always_comb begin
    w_pick = r_last_grant;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (bus.req_valid[
            IW'((int'(r_last_grant) + i) % NUM_REQ)])
        w_pick =
          IW'((int'(r_last_grant) + i) % NUM_REQ);
    end
    w_pick_oh = '0;
    w_pick_oh[w_pick] = 1'b1;
  end

  assign w_any       = |bus.req_valid;
  assign w_own_valid = bus.req_valid[r_owner];
  assign w_send      = (r_state == S_SEND) && w_own_valid;
  assign w_wd_exp    = (r_wd == TW'(TIMEOUT - 1));
  assign w_burst_end = r_last_flag ||
                       (r_beat == 8'(MAX_BURST));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_any) w_next = S_SEND;
      S_SEND: w_next = w_own_valid ? S_WAIT : S_GAP;
      S_WAIT: begin
        // A completion tick beats a watchdog expiry.
        if (bus.tx_done_tick)
          w_next = w_burst_end ? S_GAP : S_SEND;
        else if (w_wd_exp)
          w_next = S_GAP;
      end
      S_GAP:
        if (r_gap == GW'(GN - 1)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_to_gap = (w_next == S_GAP) &&
                    (r_state != S_GAP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_owner       <= '0;
      r_last_grant  <= IW'(NUM_REQ - 1);
      r_grant       <= '0;
      r_beat        <= '0;
      r_last_flag   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_wd          <= '0;
      r_gap         <= '0;
    end else begin
      r_state       <= w_next;
      r_timeout_err <= (r_state == S_WAIT) &&
                       !bus.tx_done_tick && w_wd_exp;
      if (r_state == S_IDLE && w_any) begin
        r_owner <= w_pick;
        r_grant <= w_pick_oh;
        r_beat  <= '0;
      end
      if (w_send) begin
        r_last_flag <= bus.req_last[r_owner];
        r_beat      <= r_beat + 8'd1;
      end
      // Watchdog runs only in WAIT, saturating.
      if (r_state == S_WAIT) begin
        if (!w_wd_exp) r_wd <= r_wd + TW'(1);
      end else begin
        r_wd <= '0;
      end
      if (w_to_gap) begin
        r_last_grant <= r_owner;
        r_gap        <= '0;
      end else if (r_state == S_GAP) begin
        r_gap <= r_gap + GW'(1);
      end
      if (r_state == S_GAP && w_next == S_IDLE)
        r_grant <= '0;
    end
  end

  assign bus.tx_start    = w_send;
  assign bus.tx_din      = w_send ? w_words[r_owner] : '0;
  assign bus.req_ready   = w_send ? r_grant : '0;
  assign bus.grant       = r_grant;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a
// transmitter responder and a cycle-timed reference.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int MAXB = 4;
  localparam int GAPN = 2;
  localparam int TMO  = 16;

  logic clk;
  logic reset_n;

  uart_tx_arbiter_if #(
    .NUM_REQ(NREQ), .DATA_BITS(8)
  ) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NREQ), .DATA_BITS(8),
    .MAX_BURST(MAXB), .GAP_CYCLES(GAPN),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp, n_bad;
  logic [8:0] mem [NREQ][64];
  int hd [NREQ];
  int tl [NREQ];

  int cyc, tick_at, pop_i;
  int m_owner, m_last, m_idle_at;
  int m_start_at, m_wait_s, m_terr_at, m_nb;
  bit m_end, spur, tick_now;
  int dly_lo, dly_hi;
  int nlog, n_terr;
  logic [3:0] prev_g;
  logic [3:0] glog [16];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input bit last,
                      input logic [7:0] d);
    mem[i][tl[i] % 64] = {last, d};
    tl[i]++;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++)
      if (hd[i] != tl[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Round robin: first waiting requester after
  // the previous owner, wrapping around.
  function automatic int pick();
    for (int i = 1; i <= NREQ; i++)
      if (bus.req_valid[(m_last + i) % NREQ])
        return (m_last + i) % NREQ;
    return -1;
  endfunction

  function automatic logic [31:0] logpack();
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < nlog && i < 8; i++)
      r = r | (32'(glog[i]) << (4 * i));
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      logic [8:0] w;
      bit v;
      w = mem[i][hd[i] % 64];
      v = (hd[i] != tl[i]);
      bus.req_valid[i] = v;
      bus.req_last[i]  = v & w[8];
      bus.req_data[i*8 +: 8] = v ? w[7:0] : 8'h00;
    end
  endtask

  task automatic model_clear();
    m_owner    = -1;
    m_last     = NREQ - 1;
    m_idle_at  = -1;
    m_start_at = -1;
    m_wait_s   = -1;
    m_terr_at  = -1;
    m_nb       = 0;
    m_end      = 1'b0;
    tick_at    = -1;
    pop_i      = -1;
    prev_g     = 4'h0;
    for (int i = 0; i < NREQ; i++) hd[i] = tl[i];
  endtask

  task automatic step();
    logic [3:0] eg;
    logic [8:0] w;
    bit est;
    int o;
    @(posedge clk);
    #1;
    cyc++;
    if (pop_i >= 0) begin
      hd[pop_i]++;
      pop_i = -1;
    end
    drive();
    tick_now = spur || (cyc == tick_at);
    bus.tx_done_tick = tick_now;
    @(negedge clk);
    if (cyc == m_idle_at) begin
      m_last    = m_owner;
      m_owner   = -1;
      m_idle_at = -1;
    end
    eg  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'h0;
    est = (cyc == m_start_at);
    chk("grant", bus.grant, eg);
    chk("busy", bus.busy, eg != 4'h0);
    chk("tx_start", bus.tx_start, est);
    chk("req_ready", bus.req_ready,
        est ? eg : 4'h0);
    chk("timeout_err", bus.timeout_err,
        cyc == m_terr_at);
    if (bus.timeout_err) n_terr++;
    if (bus.grant != 0 && prev_g == 0 && nlog < 16)
    begin
      glog[nlog] = bus.grant;
      nlog++;
    end
    prev_g = bus.grant;
    o = m_owner;
    if (est) begin
      w = mem[o][hd[o] % 64];
      chk("tx_din", bus.tx_din, w[7:0]);
      m_nb++;
      m_end    = w[8] || (m_nb == MAXB);
      pop_i    = o;
      m_wait_s = cyc;
      tick_at  = (dly_hi == 0) ? -1 :
        cyc + int'($urandom_range(dly_hi, dly_lo));
    end else if (m_wait_s >= 0) begin
      if (tick_now) begin
        m_wait_s = -1;
        if (m_end)
          m_idle_at = cyc + GAPN + 1;
        else if (hd[o] != tl[o])
          m_start_at = cyc + 1;
        else
          m_idle_at = cyc + GAPN + 2;
      end else if (cyc == m_wait_s + TMO) begin
        m_wait_s  = -1;
        tick_at   = -1;
        m_terr_at = cyc + 1;
        m_idle_at = cyc + GAPN + 1;
      end
    end else if (m_owner < 0 &&
                 bus.req_valid != 0) begin
      m_owner    = pick();
      m_nb       = 0;
      m_start_at = cyc + 1;
    end
  endtask

  task automatic run_quiet(input int lim);
    int n, q;
    n = 0;
    q = 0;
    while (q < 3 && n < lim) begin
      step();
      n++;
      q = (m_owner < 0 && all_empty()) ? q + 1 : 0;
    end
    chk("quiet_bound", 32'(n < lim), 32'd1);
  endtask

  task automatic run_owner(input int o);
    int n;
    n = 0;
    while (bus.grant != 4'(1 << o) && n < 60) begin
      step();
      n++;
    end
    chk("owner_bound", bus.grant, 4'(1 << o));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    nlog = 0;
    n_terr = 0;
    spur = 1'b0;
    dly_lo = 1;
    dly_hi = 15;
    for (int i = 0; i < NREQ; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    model_clear();
    clk = 1'b0;
    reset_n = 1'b0;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.tx_done_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", bus.grant, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_din", bus.tx_din, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_terr", bus.timeout_err, 0);
    reset_n = 1'b1;

    // all four with single-word bursts, req0 twice
    nlog = 0;
    for (int i = 0; i < NREQ; i++)
      push(i, 1'b1, 8'($urandom));
    push(0, 1'b1, 8'($urandom));
    run_quiet(800);
    chk("rr_order", logpack(), 32'h18421);
    chk("rr_count", nlog, 5);

    // reset in the middle of WAIT_DONE
    dly_hi = 0;
    push(0, 1'b1, 8'($urandom));
    repeat (6) step();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_grant", bus.grant, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_tx_start", bus.tx_start, 0);
    chk("mid_rst_tx_din", bus.tx_din, 0);
    chk("mid_rst_ready", bus.req_ready, 0);
    chk("mid_rst_terr", bus.timeout_err, 0);
    model_clear();
    drive();
    bus.tx_done_tick = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    dly_lo = 3;
    dly_hi = 3;
    nlog = 0;
    push(0, 1'b1, 8'($urandom));
    run_quiet(200);
    chk("post_rst_log", logpack(), 32'h1);

    // long burst capped at MAX_BURST
    dly_lo = 1;
    dly_hi = 15;
    nlog = 0;
    for (int i = 0; i < 6; i++)
      push(2, 1'b0, 8'($urandom));
    run_owner(2);
    push(0, 1'b1, 8'($urandom));
    push(3, 1'b1, 8'($urandom));
    run_quiet(1000);
    chk("burst_log", logpack(), 32'h4184);

    // owner drops valid mid-burst
    nlog = 0;
    push(1, 1'b0, 8'($urandom));
    push(1, 1'b0, 8'($urandom));
    run_owner(1);
    push(3, 1'b1, 8'($urandom));
    run_quiet(500);
    chk("drop_log", logpack(), 32'h82);

    // transmitter never answers
    dly_hi = 0;
    nlog = 0;
    n_terr = 0;
    push(1, 1'b1, 8'($urandom));
    push(2, 1'b1, 8'($urandom));
    run_quiet(500);
    chk("wd_log", logpack(), 32'h42);
    chk("wd_count", n_terr, 2);

    // tick lands exactly on watchdog expiry
    dly_lo = TMO;
    dly_hi = TMO;
    n_terr = 0;
    push(0, 1'b0, 8'($urandom));
    push(0, 1'b1, 8'($urandom));
    run_quiet(500);
    chk("race_terr", n_terr, 0);

    // spurious ticks while idle
    nlog = 0;
    spur = 1'b1;
    repeat (8) step();
    spur = 1'b0;
    chk("spur_log", nlog, 0);
    dly_lo = 1;
    dly_hi = 15;
    push(3, 1'b1, 8'($urandom));
    run_quiet(200);
    chk("spur_after", logpack(), 32'h8);

    // mixed random traffic
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        int n;
        n = int'($urandom_range(6, 0));
        for (int k = 0; k < n; k++)
          push(i, $urandom_range(2, 0) == 0,
               8'($urandom));
      end
      run_quiet(3000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
